// File: rtl/c2_line_master.sv
// Cache-side C2 bus master: turns one full-line read/write request into
// C2 command/data beats, gathers the response and returns the line or an ack.
module c2_line_master #(
    parameter int ADDR_SIZE       = 15,
    parameter int BUS_SIZE        = 16,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int TIMEOUT         = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_SIZE-1:0]         req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
    output logic                         resp_valid,
    output logic                         resp_error,
    output logic [CACHE_LINE_SIZE*8-1:0] resp_rdata,
    output logic [ADDR_SIZE-1:0]         c2_addr,
    output logic [1:0]                   c2_cmd_out,
    output logic [BUS_SIZE-1:0]          c2_data_out,
    input  logic [1:0]                   c2_cmd_in,
    input  logic [BUS_SIZE-1:0]          c2_data_in
);
    localparam int LINE_W = CACHE_LINE_SIZE * 8;
    localparam int BEATS  = LINE_W / BUS_SIZE;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    localparam logic [1:0] C2_NOP      = 2'd0;
    localparam logic [1:0] C2_RESPONSE = 2'd1;
    localparam logic [1:0] C2_READ     = 2'd2;
    localparam logic [1:0] C2_WRITE    = 2'd3;

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_WAIT, RD_BEATS, WR_BEATS, WR_WAIT, DONE
    } state_e;

    state_e                            state;
    logic [BW-1:0]                     beat;
    logic [TW-1:0]                     tcnt;
    logic [TW-1:0]                     tinc;
    logic [BEATS-1:0][BUS_SIZE-1:0]    wline;
    logic [BEATS-1:0][BUS_SIZE-1:0]    rline;
    logic [BEATS-1:0][BUS_SIZE-1:0]    rline_nxt;
    logic                              rsp;

    assign req_ready = (state == IDLE) && !reset;
    assign rsp       = (c2_cmd_in == C2_RESPONSE);
    assign tinc      = (tcnt == TMAX) ? tcnt : tcnt + 1'b1;

    // Read line including the beat arriving this cycle, so resp_rdata is
    // already complete on the resp_valid cycle.
    always_comb begin
        rline_nxt = rline;
        if ((state == RD_WAIT || state == RD_BEATS) && rsp)
            rline_nxt[beat] = c2_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_rdata  <= '0;
            c2_cmd_out  <= C2_NOP;
            c2_addr     <= '0;
            c2_data_out <= '0;
            beat        <= '0;
            tcnt        <= '0;
            wline       <= '0;
            rline       <= '0;
        end else begin
            resp_valid <= 1'b0;
            rline      <= rline_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        c2_addr <= req_addr;
                        wline   <= req_wdata;
                        beat    <= '0;
                        if (req_write) begin
                            state       <= WR_BEATS;
                            c2_cmd_out  <= C2_WRITE;
                            c2_data_out <= req_wdata[BUS_SIZE-1:0];
                        end else begin
                            state      <= RD_CMD;
                            c2_cmd_out <= C2_READ;
                        end
                    end
                end
                RD_CMD: begin
                    state      <= RD_WAIT;
                    c2_cmd_out <= C2_NOP;
                    tcnt       <= '0;
                end
                RD_WAIT: begin
                    if (rsp) begin
                        state <= RD_BEATS;
                        beat  <= beat + 1'b1;
                    end else begin
                        tcnt <= tinc;
                        if (tinc == TMAX) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= rline_nxt;
                        end
                    end
                end
                RD_BEATS: begin
                    // A gap mid-burst ends the read with whatever was captured.
                    if (!rsp || beat == LAST) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_error <= !rsp;
                        resp_rdata <= rline_nxt;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                WR_BEATS: begin
                    if (beat == LAST) begin
                        state       <= WR_WAIT;
                        c2_cmd_out  <= C2_NOP;
                        c2_data_out <= '0;
                        tcnt        <= '0;
                    end else begin
                        beat        <= beat + 1'b1;
                        c2_data_out <= wline[beat + 1'b1];
                    end
                end
                WR_WAIT: begin
                    if (rsp) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                    end else begin
                        tcnt <= tinc;
                        if (tinc == TMAX) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c2_line_master.sv
// Directed bench for c2_line_master with a cycle-stepped memory responder
// and hand-computed expectations (TIMEOUT overridden to 10).
module tb_c2_line_master;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_write;
    logic [14:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid, resp_error;
    logic [127:0] resp_rdata;
    logic [14:0]  c2_addr;
    logic [1:0]   c2_cmd_out, c2_cmd_in;
    logic [15:0]  c2_data_out, c2_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    c2_line_master #(.ADDR_SIZE(15), .BUS_SIZE(16), .CACHE_LINE_SIZE(16), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .c2_addr(c2_addr), .c2_cmd_out(c2_cmd_out), .c2_data_out(c2_data_out),
        .c2_cmd_in(c2_cmd_in), .c2_data_in(c2_data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a read; memory stays idle for wt cycles after the READ cycle,
    // then returns nb beats of base+1, base+2, ...
    task automatic rd_txn(input logic [14:0] a, input int wt, input int nb,
                          input logic [15:0] base, input bit hold,
                          output int lat, output int nread, output logic err);
        int b;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        step();
        req_valid = hold;
        lat = 0; nread = 0; err = 1'bx;
        for (int n = 1; n < 200; n++) begin
            if (c2_cmd_out == 2'd2) begin
                nread++;
                chk("rd_addr", 128'(c2_addr), 128'(a));
            end
            if (resp_valid) begin
                lat = n; err = resp_error;
                break;
            end
            if (hold) req_addr = a ^ 15'(n);
            b = n - 2 - wt;
            if (b >= 0 && b < nb) begin
                c2_cmd_in = 2'd1; c2_data_in = base + 16'(b + 1);
            end else begin
                c2_cmd_in = 2'd0; c2_data_in = 16'h0;
            end
            step();
        end
        c2_cmd_in = 2'd0; c2_data_in = 16'h0;
        step();
        chk("ready_after", 128'(req_ready), 128'd1);
    endtask

    int           lat, nrd, nw;
    logic         err, seen;
    logic [15:0]  b0, b7;
    logic [14:0]  a1;
    logic [127:0] wd;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        c2_cmd_in = 2'd0; c2_data_in = '0;
        step(); step();
        chk("rst_ready", 128'(req_ready), 128'd0);
        chk("rst_valid", 128'(resp_valid), 128'd0);
        chk("rst_cmd", 128'(c2_cmd_out), 128'd0);
        chk("rst_rdata", resp_rdata, 128'd0);
        chk("rst_addr", 128'(c2_addr), 128'd0);
        reset = 1'b0;
        #1;
        chk("rdy_post_rst", 128'(req_ready), 128'd1);

        // plain read, 5 idle cycles
        rd_txn(15'h0ABC, 5, 8, 16'h0000, 1'b0, lat, nrd, err);
        chk("rd1_lat", 128'(lat), 128'd15);
        chk("rd1_err", 128'(err), 128'd0);
        chk("rd1_nread", 128'(nrd), 128'd1);
        chk("rd1_data", resp_rdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

        // write, stray RESPONSE during beats, real one after 3 idle cycles
        wd = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h1234; req_wdata = wd;
        step();
        req_valid = 1'b0; req_write = 1'b0;
        nw = 0; lat = 0; b0 = '0; b7 = '0; a1 = '0; err = 1'bx;
        for (int n = 1; n < 60; n++) begin
            if (c2_cmd_out == 2'd3) nw++;
            if (n == 1) begin b0 = c2_data_out; a1 = c2_addr; end
            if (n == 8) b7 = c2_data_out;
            if (resp_valid) begin lat = n; err = resp_error; break; end
            c2_cmd_in = (n == 3 || n == 12) ? 2'd1 : 2'd0;
            step();
        end
        c2_cmd_in = 2'd0;
        chk("wr_nbeats", 128'(nw), 128'd8);
        chk("wr_beat0", 128'(b0), 128'h1100);
        chk("wr_beat7", 128'(b7), 128'hFFEE);
        chk("wr_addr", 128'(a1), 128'h1234);
        chk("wr_lat", 128'(lat), 128'd13);
        chk("wr_err", 128'(err), 128'd0);
        chk("wr_rdata_kept", resp_rdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        step();

        // no response at all -> timeout 10 cycles into RD_WAIT
        rd_txn(15'h0001, 0, 0, 16'h0000, 1'b0, lat, nrd, err);
        chk("to_lat", 128'(lat), 128'd12);
        chk("to_err", 128'(err), 128'd1);

        // first beat on the very cycle the count reaches TIMEOUT: response wins
        rd_txn(15'h0002, 9, 8, 16'h0010, 1'b0, lat, nrd, err);
        chk("tob_lat", 128'(lat), 128'd19);
        chk("tob_err", 128'(err), 128'd0);
        chk("tob_data", resp_rdata, 128'h0018_0017_0016_0015_0014_0013_0012_0011);

        // burst broken after beat 3
        rd_txn(15'h0003, 2, 4, 16'hA000, 1'b0, lat, nrd, err);
        chk("pe_lat", 128'(lat), 128'd9);
        chk("pe_err", 128'(err), 128'd1);
        chk("pe_data", resp_rdata, 128'h0018_0017_0016_0015_A004_A003_A002_A001);

        // reset while driving write beat 4
        req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0055; req_wdata = wd;
        step();
        req_valid = 1'b0; req_write = 1'b0;
        for (int n = 1; n < 5; n++) step();
        chk("rw_beat4", 128'(c2_data_out), 128'h9988);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rw_cmd", 128'(c2_cmd_out), 128'd0);
        chk("rw_rdata", resp_rdata, 128'd0);
        seen = resp_valid;
        c2_cmd_in = 2'd1;
        for (int n = 0; n < 3; n++) begin step(); seen |= resp_valid; end
        c2_cmd_in = 2'd0;
        chk("rw_no_resp", 128'(seen), 128'd0);
        chk("rw_ready", 128'(req_ready), 128'd1);
        rd_txn(15'h0066, 0, 8, 16'hB000, 1'b0, lat, nrd, err);
        chk("rw_rd_lat", 128'(lat), 128'd10);
        chk("rw_rd_err", 128'(err), 128'd0);
        chk("rw_rd_data", resp_rdata, 128'hB008_B007_B006_B005_B004_B003_B002_B001);

        // req_valid held with changing addr: only first addr issued
        rd_txn(15'h0100, 0, 8, 16'hC000, 1'b1, lat, nrd, err);
        chk("hold_lat", 128'(lat), 128'd10);
        chk("hold_nread", 128'(nrd), 128'd1);
        req_addr = 15'h7777;
        step();
        chk("hold_reissue_cmd", 128'(c2_cmd_out), 128'd2);
        chk("hold_reissue_addr", 128'(c2_addr), 128'h7777);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && !resp_valid; i++) step();
        chk("hold_drain", 128'(resp_valid), 128'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
